ramlinebuffer: RTL and testbench
================================

RAMLINEBUFFER -- requirements
Module: ramlinebuffer

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, pixel width in bits.
REQ-002 SHALL have parameter DELAY_P, default 8, line length in samples; legal range 2 or more.
REQ-003 SHALL have parameter TAPS_P, default 3, number of row taps; legal range 2 or more.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_i, input, WIDTH_P, incoming pixel.
REQ-007 SHALL have port valid_i, input, 1, data_i valid.
REQ-008 SHALL have port ready_o, output, 1, block accepts data_i.
REQ-009 SHALL have port taps_o, output, TAPS_P*WIDTH_P, column of pixels; slice k is the sample from k lines earlier.
REQ-010 SHALL have port valid_o, output, 1, taps_o valid.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts taps_o.
REQ-012 SHALL have port primed_o, output, 1, all TAPS_P taps hold real data.

Function
REQ-013 SHALL define accept as valid_i && ready_o, and consume as valid_o && ready_i.
REQ-014 SHALL drive ready_o = !valid_o || ready_i, combinationally.
REQ-015 SHALL present taps_o and valid_o one cycle after accept, with latency exactly 1.
REQ-016 SHALL hold taps_o and valid_o stable while valid_o && !ready_i.
REQ-017 SHALL clear valid_o on consume without a same-cycle accept.
REQ-018 SHALL implement slice 0 as a register loaded with data_i on accept.
REQ-019 SHALL implement slices 1..TAPS_P-1 as synchronous RAM read data, read at rd_ptr on accept, read-enable = accept.
REQ-020 SHALL, on consume, write taps_o slice k-1 into line RAM k at the address of the sample currently on taps_o.
REQ-021 SHALL advance rd_ptr by 1 per accept, wrapping DELAY_P-1 -> 0.
REQ-022 SHALL never read and write the same RAM address in one cycle; this follows from DELAY_P >= 2.
REQ-023 SHALL keep fill count, saturating at DELAY_P*(TAPS_P-1), incremented per accept.
REQ-024 SHALL force slice k of taps_o to zero while the fill count at that sample was below k*DELAY_P; this masks uninitialised RAM.
REQ-025 SHALL assert primed_o with valid_o when no slice is masked.
REQ-026 SHALL, on simultaneous consume and accept, write the old output and load the new one in the same cycle, with no bubble.

Reset
REQ-027 SHALL, on rstn_i low, asynchronously set valid_o=0, taps_o=0, primed_o=0, rd_ptr=0 and fill=0.
REQ-028 SHALL not reset RAM contents; masking per REQ-024 covers this.
REQ-029 SHALL, after reset mid-stream, restart filling from zero with no stale data visible.

Configuration
REQ-030 SHALL, with RAMLINEBUFFER_FLUSH_EN defined, add input flush_i (1 bit), which is synchronous.
REQ-031 SHALL give flush_i priority over accept, clear rd_ptr, fill, valid_o and primed_o next cycle, and force ready_o=0 while high.
REQ-032 SHALL, without RAMLINEBUFFER_FLUSH_EN, omit flush_i, leaving behaviour otherwise identical.

Structure
REQ-033 SHALL place the fill-limit function, pointer-width function ($clog2(DELAY_P)) and the tap-slice type in package ramlinebuffer_pkg.
REQ-034 SHALL instantiate existing sub-module sync_ram_block TAPS_P-1 times (WIDTH_P x DELAY_P each); there is no other sub-module.

Verification (WIDTH_P=8, DELAY_P=4, TAPS_P=3)
REQ-035 SHALL check: reset, then stream 1,2,...,12 with ready_i=1 -> sample 9 output taps_o={1,5,9}, primed_o first high there; samples 1-8 show masked zeros in upper slices.
REQ-036 SHALL check: stream 1..4 -> outputs {0,0,1}..{0,0,4}, primed_o=0, ready_o=1 throughout.
REQ-037 SHALL check: ready_i=0 for 5 cycles with valid_i=1 -> ready_o=0 and taps_o held; release -> next sample arrives one cycle later with no loss and no duplicate.
REQ-038 SHALL check: continuous 20 samples with ready_i toggled randomly -> every output column equals {n-8,n-4,n}, and rd_ptr wraps correctly.
REQ-039 SHALL check: rstn_i pulsed after sample 10 -> all outputs 0 immediately; new stream 50.. -> upper slices zero until fill conditions are met again.
REQ-040 SHALL check, with RAMLINEBUFFER_FLUSH_EN defined: flush_i after sample 10 -> valid_o=0 and primed_o=0 next cycle, and next accepted sample shows {0,0,x}.

Source files
------------

// File: rtl/ramlinebuffer_pkg.sv
// Shared helpers for the ramlinebuffer line-buffer slice: sizing functions and
// the default tap-slice type.
package ramlinebuffer_pkg;

    localparam int unsigned TAP_WIDTH_DEF = 8;

    typedef logic [TAP_WIDTH_DEF-1:0] tap_slice_t;

    // Fill count at which every tap line holds written data.
    function automatic int fill_limit(input int delay, input int taps);
        return delay * (taps - 1);
    endfunction

    function automatic int ptr_width(input int delay);
        return (delay > 1) ? $clog2(delay) : 1;
    endfunction

endpackage

// File: rtl/sync_ram_block.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// whose output holds while the read enable is low. Contents are not reset.
module sync_ram_block #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 8,
    parameter int ADDR_W_P = 3
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W_P-1:0] waddr_i,
    input  logic [WIDTH_P-1:0]  wdata_i,
    input  logic                re_i,
    input  logic [ADDR_W_P-1:0] raddr_i,
    output logic [WIDTH_P-1:0]  rdata_o
);

    logic [WIDTH_P-1:0] r_mem [DEPTH_P];
    logic [WIDTH_P-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/ramlinebuffer.sv
// RAM-based line buffer producing a column of TAPS_P vertically aligned pixels.
// Optional synchronous flush input is enabled by defining RAMLINEBUFFER_FLUSH_EN.
module ramlinebuffer
    import ramlinebuffer_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int DELAY_P = 8,
    parameter int TAPS_P  = 3
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
`ifdef RAMLINEBUFFER_FLUSH_EN
    input  logic                      flush_i,
`endif
    input  logic [WIDTH_P-1:0]        data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [TAPS_P*WIDTH_P-1:0] taps_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      primed_o
);

    localparam int PTR_W    = ptr_width(DELAY_P);
    localparam int FILL_MAX = fill_limit(DELAY_P, TAPS_P);
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    // Handshake: a sample is accepted when valid_i && ready_o and the output
    // column is consumed when valid_o && ready_i; both may happen in one cycle.
    logic w_flush;
    logic w_accept;
    logic w_consume;

`ifdef RAMLINEBUFFER_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    logic                      r_valid;
    logic                      r_primed;
    logic [WIDTH_P-1:0]        r_s0;
    logic [TAPS_P-2:0]         r_mask;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W-1:0]          r_wr_addr;
    logic [FILL_W-1:0]         r_fill;

    logic [TAPS_P-2:0]         w_mask_next;
    logic [TAPS_P*WIDTH_P-1:0] w_taps;
    logic [WIDTH_P-1:0]        w_ram_rdata [1:TAPS_P-1];

    assign ready_o   = !w_flush && (!r_valid || ready_i);
    assign w_accept  = valid_i && ready_o;
    assign w_consume = r_valid && ready_i;

    assign w_taps[WIDTH_P-1:0] = r_s0;

    // Line RAM k holds the slice k-1 values of the previous line, written back
    // when that column leaves; its read for the new sample overlaps the write
    // of the previous sample, which is always a different address.
    for (genvar k = 1; k < TAPS_P; k++) begin : g_line
        assign w_mask_next[k-1] = (r_fill < FILL_W'(k * DELAY_P));
        assign w_taps[k*WIDTH_P +: WIDTH_P] = r_mask[k-1] ? '0 : w_ram_rdata[k];

        sync_ram_block #(
            .WIDTH_P (WIDTH_P),
            .DEPTH_P (DELAY_P),
            .ADDR_W_P(PTR_W)
        ) u_ram (
            .clk_i  (clk_i),
            .we_i   (w_consume),
            .waddr_i(r_wr_addr),
            .wdata_i(w_taps[(k-1)*WIDTH_P +: WIDTH_P]),
            .re_i   (w_accept),
            .raddr_i(r_rd_ptr),
            .rdata_o(w_ram_rdata[k])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_primed  <= 1'b0;
            r_s0      <= '0;
            r_mask    <= '1;
            r_rd_ptr  <= '0;
            r_wr_addr <= '0;
            r_fill    <= '0;
        end else if (w_flush) begin
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_primed  <= !(|w_mask_next);
            r_s0      <= data_i;
            r_mask    <= w_mask_next;
            r_wr_addr <= r_rd_ptr;
            r_rd_ptr  <= (r_rd_ptr == PTR_W'(DELAY_P - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            if (r_fill != FILL_W'(FILL_MAX)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end else if (w_consume) begin
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
        end
    end

    assign taps_o   = w_taps;
    assign valid_o  = r_valid;
    assign primed_o = r_primed;

endmodule

// File: tb/tb_ramlinebuffer.sv
// Self-checking bench for ramlinebuffer (WIDTH_P=8, DELAY_P=4, TAPS_P=3); flush
// scenario is included when RAMLINEBUFFER_FLUSH_EN is defined.
module tb_ramlinebuffer;
    import ramlinebuffer_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int T  = 3;
    localparam int TW = T * W;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          flush    = 1'b0;
    logic [W-1:0]  data     = '0;
    logic          valid_in = 1'b0;
    logic          rdy_out;
    logic [TW-1:0] taps;
    logic          valid_out;
    logic          rdy_in   = 1'b1;
    logic          primed;

    int n_checks = 0;
    int n_fail   = 0;

    ramlinebuffer #(.WIDTH_P(W), .DELAY_P(D), .TAPS_P(T)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
`ifdef RAMLINEBUFFER_FLUSH_EN
        .flush_i (flush),
`endif
        .data_i  (data),
        .valid_i (valid_in),
        .ready_o (rdy_out),
        .taps_o  (taps),
        .valid_o (valid_out),
        .ready_i (rdy_in),
        .primed_o(primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of accepted samples since reset/flush; column
    // slice k is the sample k*D positions back, zero if it does not exist yet.
    tap_slice_t    hist[$];
    logic [TW:0]   exp_q[$];
    logic [TW:0]   m_col;
    logic          m_valid;
    logic          m_ready;
    int            m_c;

    always @(negedge clk) begin
        if (!rstn) begin
            hist.delete();
            exp_q.delete();
        end else begin
            m_valid = (exp_q.size() != 0);
            m_ready = !flush && (!m_valid || rdy_in);
            check("mon_valid_o", 32'(valid_out), 32'(m_valid));
            check("mon_ready_o", 32'(rdy_out), 32'(m_ready));
            if (m_valid && rdy_in) begin
                m_col = exp_q.pop_front();
                check("mon_taps_o", 32'(taps), 32'(m_col[TW-1:0]));
                check("mon_primed_o", 32'(primed), 32'(m_col[TW]));
            end
            if (flush) begin
                hist.delete();
                exp_q.delete();
            end else if (valid_in && m_ready) begin
                hist.push_back(data);
                m_c   = hist.size() - 1;
                m_col = '0;
                for (int k = 0; k < T; k++) begin
                    if (m_c >= k * D) m_col[k*W +: W] = hist[m_c - k*D];
                end
                m_col[TW] = (m_c >= (T - 1) * D);
                exp_q.push_back(m_col);
            end
        end
    end

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] taps;
        logic          primed;
    } vec_t;

    vec_t vec [12];

    task automatic do_reset();
        valid_in = 1'b0;
        rdy_in   = 1'b1;
        flush    = 1'b0;
        rstn     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] d);
        valid_in = 1'b1;
        data     = d;
        @(posedge clk);
        #1;
    endtask

    int n;
    int cycles;

    initial begin
        vec[0]  = '{8'd1,  24'h000001, 1'b0};
        vec[1]  = '{8'd2,  24'h000002, 1'b0};
        vec[2]  = '{8'd3,  24'h000003, 1'b0};
        vec[3]  = '{8'd4,  24'h000004, 1'b0};
        vec[4]  = '{8'd5,  24'h000105, 1'b0};
        vec[5]  = '{8'd6,  24'h000206, 1'b0};
        vec[6]  = '{8'd7,  24'h000307, 1'b0};
        vec[7]  = '{8'd8,  24'h000408, 1'b0};
        vec[8]  = '{8'd9,  24'h010509, 1'b1};
        vec[9]  = '{8'd10, 24'h02060a, 1'b1};
        vec[10] = '{8'd11, 24'h03070b, 1'b1};
        vec[11] = '{8'd12, 24'h04080c, 1'b1};

        // Reset state
        do_reset();
        check("rst_valid_o", 32'(valid_out), 32'd0);
        check("rst_taps_o", 32'(taps), 32'd0);
        check("rst_primed_o", 32'(primed), 32'd0);
        check("rst_ready_o", 32'(rdy_out), 32'd1);

        // Streaming table 1..12, ready_i held high
        for (int i = 0; i < 12; i++) begin
            send(vec[i].d);
            check("tbl_valid_o", 32'(valid_out), 32'd1);
            check("tbl_taps_o", 32'(taps), 32'(vec[i].taps));
            check("tbl_primed_o", 32'(primed), 32'(vec[i].primed));
            check("tbl_ready_o", 32'(rdy_out), 32'd1);
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("tbl_drop_valid_o", 32'(valid_out), 32'd0);

        // Back-pressure for 5 cycles with a sample waiting
        do_reset();
        send(8'h11);
        rdy_in = 1'b0;
        data   = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready_o", 32'(rdy_out), 32'd0);
            check("stall_valid_o", 32'(valid_out), 32'd1);
            check("stall_taps_o", 32'(taps), 32'h000011);
        end
        rdy_in = 1'b1;
        #1;
        check("release_ready_o", 32'(rdy_out), 32'd1);
        @(posedge clk);
        #1;
        check("release_taps_o", 32'(taps), 32'h000022);
        check("release_valid_o", 32'(valid_out), 32'd1);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("release_drain_valid_o", 32'(valid_out), 32'd0);

        // 20 continuous samples with random downstream ready
        do_reset();
        n = 1;
        cycles = 0;
        while (n <= 20 && cycles < 400) begin
            valid_in = 1'b1;
            data     = W'(n);
            rdy_in   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rdy_out) n++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("rand_stream_done", 32'(n), 32'd21);
        valid_in = 1'b0;
        rdy_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rand_stream_drained", 32'(exp_q.size()), 32'd0);

        // Random valid, data and ready
        do_reset();
        for (int i = 0; i < 80; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data     = W'($urandom);
            rdy_in   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        rdy_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rand_mix_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream, then refill from 50
        do_reset();
        for (int i = 1; i <= 10; i++) send(W'(i));
        valid_in = 1'b0;
        rdy_in   = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_taps_o", 32'(taps), 32'h02060a);
        rstn = 1'b0;
        #1;
        check("midrst_valid_o", 32'(valid_out), 32'd0);
        check("midrst_taps_o", 32'(taps), 32'd0);
        check("midrst_primed_o", 32'(primed), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn   = 1'b1;
        rdy_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(W'(50 + i));
            if (i == 0) check("restart_first_taps", 32'(taps), 32'h000032);
            if (i == 5) check("restart_s1_taps", 32'(taps), 32'h003337);
            if (i == 7) check("restart_unprimed", 32'(primed), 32'd0);
            if (i == 8) begin
                check("restart_primed_taps", 32'(taps), 32'h32363a);
                check("restart_primed", 32'(primed), 32'd1);
            end
        end
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef RAMLINEBUFFER_FLUSH_EN
        // Flush after 10 samples
        do_reset();
        for (int i = 1; i <= 10; i++) send(W'(i));
        flush    = 1'b1;
        valid_in = 1'b1;
        data     = 8'h99;
        #1;
        check("flush_ready_o", 32'(rdy_out), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid_o", 32'(valid_out), 32'd0);
        check("flush_primed_o", 32'(primed), 32'd0);
        send(8'h77);
        check("post_flush_taps", 32'(taps), 32'h000077);
        check("post_flush_primed", 32'(primed), 32'd0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
